// File: rtl/aslave_regbank.sv
// Avalon-MM slave register bank: byte-enabled bus writes, programmable read wait
// states, per-register read-only mask and a user-side update/strobe port.
module aslave_regbank #(
  parameter int               ADDRW   = 8,
  parameter int               DATAW   = 32,
  parameter int               DEPTH   = 16,
  parameter int               RD_WAIT = 1,
  parameter logic [DEPTH-1:0] RO_MASK = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDRW-1:0]       sl_addr,
  input  logic                   sl_read,
  input  logic                   sl_write,
  input  logic [DATAW/8-1:0]     sl_byteenable,
  input  logic [DATAW-1:0]       sl_writedata,
  output logic [DATAW-1:0]       sl_readdata,
  output logic                   sl_waitrequest,
  output logic [1:0]             sl_response,
  input  logic [ADDRW-1:0]       us_addr,
  input  logic                   us_write,
  input  logic [DATAW-1:0]       us_wdata,
  output logic [DEPTH-1:0]       us_wstrobe,
  output logic                   us_collide,
  output logic [DEPTH*DATAW-1:0] us_regs
);

  localparam int              NBYTE     = DATAW / 8;
  localparam int              IDXW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRW:0]  DEPTH_A   = (ADDRW + 1)'(DEPTH);
  localparam logic [2:0]      WAIT_LOAD = (RD_WAIT > 0) ? 3'(RD_WAIT - 1) : 3'd0;

  typedef enum logic [1:0] {IDLE, RWAIT, RDONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       cnt, cnt_nxt;
  logic [ADDRW-1:0] rd_addr_q, rd_addr;
  logic             rd_latch, wait_raw;
  logic [DATAW-1:0] regs [DEPTH];

  logic             bus_valid, us_valid, rd_valid;
  logic             bus_wr, bus_wr_ok, collide;
  logic [IDXW-1:0]  bus_idx, us_idx, rd_idx;
  logic [DEPTH-1:0] bus_sel, us_sel;

  assign bus_idx   = sl_addr[IDXW-1:0];
  assign us_idx    = us_addr[IDXW-1:0];
  assign rd_idx    = rd_addr[IDXW-1:0];
  assign bus_valid = {1'b0, sl_addr} < DEPTH_A;
  assign us_valid  = {1'b0, us_addr} < DEPTH_A;
  assign rd_valid  = {1'b0, rd_addr} < DEPTH_A;

  // A write in IDLE always wins over a simultaneous read; only a write that
  // really lands in a register can collide with the user port.
  assign bus_wr    = (state == IDLE) && sl_write;
  assign bus_wr_ok = bus_wr && bus_valid && !RO_MASK[bus_idx];
  assign collide   = bus_wr_ok && us_write && (sl_addr == us_addr);

  always_comb begin
    bus_sel = '0;
    us_sel  = '0;
    if (bus_wr_ok) bus_sel[bus_idx] = 1'b1;
    if (us_write && us_valid && !collide) us_sel[us_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_addr_q <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rd_addr_q <= rd_addr;
    end
  end

  // The read address is captured on entry so master-side changes during
  // RWAIT have no effect on the returned data.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wait_raw  = 1'b0;
    rd_latch  = 1'b0;
    rd_addr   = rd_addr_q;
    unique case (state)
      IDLE: begin
        if (sl_read && !sl_write) begin
          rd_addr = sl_addr;
          if (RD_WAIT == 0) begin
            rd_latch  = 1'b1;
            state_nxt = RDONE;
          end else begin
            wait_raw  = 1'b1;
            cnt_nxt   = WAIT_LOAD;
            state_nxt = RWAIT;
          end
        end
      end
      RWAIT: begin
        wait_raw = (cnt != 3'd0);
        if (cnt == 3'd0) begin
          rd_latch  = 1'b1;
          state_nxt = RDONE;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      RDONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by reset so a master still holding sl_read sees the stall drop at once.
  assign sl_waitrequest = wait_raw && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus_sel[i]) begin
          for (int k = 0; k < NBYTE; k++)
            if (sl_byteenable[k]) regs[i][8*k +: 8] <= sl_writedata[8*k +: 8];
        end else if (us_sel[i]) begin
          regs[i] <= us_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sl_readdata <= '0;
      sl_response <= 2'b00;
      us_wstrobe  <= '0;
      us_collide  <= 1'b0;
    end else begin
      us_wstrobe <= bus_sel;
      us_collide <= collide;
      if (bus_wr) begin
        sl_response <= (sl_read || !bus_wr_ok) ? 2'b10 : 2'b00;
      end else if (rd_latch) begin
        sl_readdata <= rd_valid ? regs[rd_idx] : '0;
        sl_response <= rd_valid ? 2'b00 : 2'b10;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign us_regs[g*DATAW +: DATAW] = regs[g];
  end

endmodule

// File: tb/tb_aslave_regbank.sv
// Self-checking bench for aslave_regbank: directed scenarios with literal
// expectations, then random bus/user traffic checked against a behavioural model.
module tb_aslave_regbank;

  localparam int               ADDRW   = 8;
  localparam int               DATAW   = 32;
  localparam int               DEPTH   = 16;
  localparam int               RD_WAIT = 2;
  localparam logic [DEPTH-1:0] RO_MASK = 16'h0004;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [ADDRW-1:0]       sl_addr = '0;
  logic                   sl_read = 1'b0;
  logic                   sl_write = 1'b0;
  logic [DATAW/8-1:0]     sl_byteenable = '0;
  logic [DATAW-1:0]       sl_writedata = '0;
  logic [DATAW-1:0]       sl_readdata;
  logic                   sl_waitrequest;
  logic [1:0]             sl_response;
  logic [ADDRW-1:0]       us_addr = '0;
  logic                   us_write = 1'b0;
  logic [DATAW-1:0]       us_wdata = '0;
  logic [DEPTH-1:0]       us_wstrobe;
  logic                   us_collide;
  logic [DEPTH*DATAW-1:0] us_regs;

  aslave_regbank #(
    .ADDRW(ADDRW), .DATAW(DATAW), .DEPTH(DEPTH), .RD_WAIT(RD_WAIT), .RO_MASK(RO_MASK)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sl_addr(sl_addr), .sl_read(sl_read), .sl_write(sl_write),
    .sl_byteenable(sl_byteenable), .sl_writedata(sl_writedata),
    .sl_readdata(sl_readdata), .sl_waitrequest(sl_waitrequest), .sl_response(sl_response),
    .us_addr(us_addr), .us_write(us_write), .us_wdata(us_wdata),
    .us_wstrobe(us_wstrobe), .us_collide(us_collide), .us_regs(us_regs)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en  = 1'b0;
  bit random_us = 1'b0;

  // Reference model: register contents plus the read timeline, where a read
  // issued in cycle 0 stalls while its cycle index is below RD_WAIT, latches at
  // index RD_WAIT, and the following cycle is a dead "done" cycle.
  logic [DATAW-1:0] m_regs [DEPTH];
  logic [DATAW-1:0] m_rdata;
  logic [1:0]       m_resp;
  logic [DEPTH-1:0] m_strobe;
  logic             m_collide;
  int               m_rd_el;
  int               m_rd_addr;
  bit               m_done;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [DATAW-1:0] dut_reg(input int i);
    return us_regs[i*DATAW +: DATAW];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
    m_rdata = '0; m_resp = 2'b00; m_strobe = '0; m_collide = 1'b0;
    m_rd_el = -1; m_rd_addr = 0; m_done = 1'b0;
  endtask

  task automatic model_step();
    int c, a, bus_hit;
    bit idle_now;
    logic [DATAW-1:0] nv;
    idle_now  = !m_done && (m_rd_el < 0);
    bus_hit   = -1;
    m_strobe  = '0;
    m_collide = 1'b0;
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_rd_el >= 0 || (sl_read && !sl_write)) begin
      if (m_rd_el < 0) begin
        m_rd_addr = int'(sl_addr);
        c = 0;
      end else begin
        c = m_rd_el;
      end
      if (c == RD_WAIT) begin
        m_rdata = (m_rd_addr < DEPTH) ? m_regs[m_rd_addr] : '0;
        m_resp  = (m_rd_addr < DEPTH) ? 2'b00 : 2'b10;
        m_done  = 1'b1;
        m_rd_el = -1;
      end else begin
        m_rd_el = c + 1;
      end
    end
    if (idle_now && sl_write) begin
      a = int'(sl_addr);
      if (a < DEPTH && !RO_MASK[a]) begin
        nv = m_regs[a];
        for (int k = 0; k < DATAW/8; k++)
          if (sl_byteenable[k]) nv[8*k +: 8] = sl_writedata[8*k +: 8];
        m_regs[a]   = nv;
        m_strobe[a] = 1'b1;
        bus_hit     = a;
      end
      m_resp = (sl_read || bus_hit < 0) ? 2'b10 : 2'b00;
    end
    if (us_write && int'(us_addr) < DEPTH) begin
      if (int'(us_addr) == bus_hit) m_collide = 1'b1;
      else m_regs[us_addr[3:0]] = us_wdata;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  initial begin
    bit exp_wr;
    forever begin
      @(negedge clk);
      if (check_en) begin
        if (!rst_n) exp_wr = 1'b0;
        else if (m_done) exp_wr = 1'b0;
        else if (m_rd_el >= 0) exp_wr = (m_rd_el < RD_WAIT);
        else exp_wr = sl_read && !sl_write && (RD_WAIT > 0);
        checkOutput("waitrequest", 32'(sl_waitrequest), 32'(exp_wr));
        checkOutput("readdata", sl_readdata, m_rdata);
        checkOutput("response", 32'(sl_response), 32'(m_resp));
        checkOutput("wstrobe", 32'(us_wstrobe), 32'(m_strobe));
        checkOutput("collide", 32'(us_collide), 32'(m_collide));
        for (int i = 0; i < DEPTH; i++)
          checkOutput($sformatf("reg%0d", i), dut_reg(i), m_regs[i]);
      end
    end
  end

  // Background user-side traffic, biased toward the bus address to provoke collisions.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (random_us) begin
        us_write = ($urandom_range(0, 2) == 0);
        us_addr  = ($urandom_range(0, 3) == 0) ? sl_addr : 8'($urandom_range(0, 19));
        us_wdata = $urandom;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [ADDRW-1:0] a, input logic [DATAW-1:0] d,
                          input logic [3:0] be, input bit with_read);
    sl_addr = a; sl_writedata = d; sl_byteenable = be;
    sl_write = 1'b1; sl_read = with_read;
    next_cycle();
    sl_write = 1'b0; sl_read = 1'b0;
  endtask

  task automatic busRead(input logic [ADDRW-1:0] a, output logic [DATAW-1:0] data, output int waits);
    bit accepted;
    sl_addr = a; sl_read = 1'b1; sl_write = 1'b0;
    waits = 0; accepted = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (!sl_waitrequest) begin
        accepted = 1'b1;
        break;
      end
      waits++;
    end
    checkOutput("read_accepted", 32'(accepted), 32'd1);
    next_cycle();
    sl_read = 1'b0;
    data = sl_readdata;
    next_cycle();
  endtask

  task automatic applyStimulus(input int n_ops);
    logic [DATAW-1:0] d;
    int w, op;
    logic [ADDRW-1:0] a;
    for (int i = 0; i < n_ops; i++) begin
      op = $urandom_range(0, 9);
      a  = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 19));
      case (op)
        0, 1, 2, 3: busWrite(a, $urandom, 4'($urandom_range(0, 15)), 1'b0);
        4, 5, 6:    busRead(a, d, w);
        7:          busWrite(a, $urandom, 4'($urandom_range(0, 15)), 1'b1);
        default:    next_cycle();
      endcase
    end
  endtask

  initial begin
    logic [DATAW-1:0] d;
    int w;
    @(posedge clk);
    check_en = 1'b1;
    #1;
    checkOutput("rst_readdata", sl_readdata, 32'h0);
    checkOutput("rst_response", 32'(sl_response), 32'h0);
    checkOutput("rst_waitrequest", 32'(sl_waitrequest), 32'h0);
    checkOutput("rst_wstrobe", 32'(us_wstrobe), 32'h0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Read after reset: two stall cycles, zero data, OKAY.
    busRead(8'd3, d, w);
    checkOutput("t1_waits", 32'(w), 32'd2);
    checkOutput("t1_data", d, 32'h0);
    checkOutput("t1_resp", 32'(sl_response), 32'h0);

    // Byte-lane merge and a single strobe pulse.
    busWrite(8'd1, 32'h11223344, 4'hF, 1'b0);
    next_cycle();
    busWrite(8'd1, 32'hA5A5A5A5, 4'b0101, 1'b0);
    checkOutput("t2_reg1", dut_reg(1), 32'h11A533A5);
    checkOutput("t2_model_reg1", m_regs[1], 32'h11A533A5);
    checkOutput("t2_strobe", 32'(us_wstrobe), 32'h0002);
    next_cycle();
    checkOutput("t2_strobe_off", 32'(us_wstrobe), 32'h0);

    // Read-only register: bus write refused, user write accepted.
    busWrite(8'd2, 32'hDEADBEEF, 4'hF, 1'b0);
    checkOutput("t3_reg2", dut_reg(2), 32'h0);
    checkOutput("t3_resp", 32'(sl_response), 32'h2);
    checkOutput("t3_strobe", 32'(us_wstrobe), 32'h0);
    us_addr = 8'd2; us_wdata = 32'hCAFE0001; us_write = 1'b1;
    next_cycle();
    us_write = 1'b0;
    busRead(8'd2, d, w);
    checkOutput("t3_read", d, 32'hCAFE0001);
    checkOutput("t3_read_resp", 32'(sl_response), 32'h0);

    // Collision on the same register, then independent registers.
    us_addr = 8'd5; us_wdata = 32'h2; us_write = 1'b1;
    busWrite(8'd5, 32'h1, 4'hF, 1'b0);
    us_write = 1'b0;
    checkOutput("t4_reg5", dut_reg(5), 32'h1);
    checkOutput("t4_collide", 32'(us_collide), 32'h1);
    next_cycle();
    checkOutput("t4_collide_off", 32'(us_collide), 32'h0);
    us_addr = 8'd6; us_wdata = 32'h2; us_write = 1'b1;
    busWrite(8'd5, 32'h1, 4'hF, 1'b0);
    us_write = 1'b0;
    checkOutput("t4b_reg5", dut_reg(5), 32'h1);
    checkOutput("t4b_reg6", dut_reg(6), 32'h2);
    checkOutput("t4b_collide", 32'(us_collide), 32'h0);

    // Out-of-range address.
    busRead(8'h20, d, w);
    checkOutput("t5_data", d, 32'h0);
    checkOutput("t5_resp", 32'(sl_response), 32'h2);
    busWrite(8'h20, 32'hFFFFFFFF, 4'hF, 1'b0);
    checkOutput("t5_wr_resp", 32'(sl_response), 32'h2);
    checkOutput("t5_wr_strobe", 32'(us_wstrobe), 32'h0);
    checkOutput("t5_reg0", dut_reg(0), 32'h0);
    checkOutput("t5_reg1", dut_reg(1), 32'h11A533A5);

    // Reset in the middle of a stalled read.
    sl_addr = 8'd1; sl_read = 1'b1;
    next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_waitrequest", 32'(sl_waitrequest), 32'h0);
    checkOutput("t6_reg1", dut_reg(1), 32'h0);
    checkOutput("t6_readdata", sl_readdata, 32'h0);
    sl_read = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    busRead(8'd1, d, w);
    checkOutput("t6_waits", 32'(w), 32'd2);
    checkOutput("t6_data", d, 32'h0);

    random_us = 1'b1;
    applyStimulus(400);
    random_us = 1'b0;
    next_cycle();
    us_write = 1'b0;
    next_cycle();
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/aslave_regbank.md
Name: aslave_regbank

Overview:
Parametrised Avalon-MM slave register bank with a byte-enabled bus port, programmable read wait states, and a user-side (us_) hardware port. Software reads and writes registers over the sl_ interface. User logic updates status registers and receives per-register write strobes over the us_ interface. It sits between the system interconnect and a peripheral core, and supersedes the fixed 8-bit/32-bit single-mode slave.

Parameters:
ADDRW, 8, word address width on both ports
DATAW, 32, data width; must be a multiple of 8
DEPTH, 16, number of implemented registers; DEPTH <= 2**ADDRW
RD_WAIT, 1, read wait-state cycles, 0..7
RO_MASK, 0, DEPTH-bit mask; bit i=1 makes register i read-only from the bus

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sl_addr  in  ADDRW  bus word address
sl_read  in  1  bus read request
sl_write  in  1  bus write request
sl_byteenable  in  DATAW/8  bus byte lanes
sl_writedata  in  DATAW  bus write data
sl_readdata  out  DATAW  bus read data
sl_waitrequest  out  1  bus stall
sl_response  out  2  00=OKAY, 10=SLVERR
us_addr  in  ADDRW  user-side register address
us_write  in  1  user-side write
us_wdata  in  DATAW  user-side write data
us_wstrobe  out  DEPTH  one-cycle pulse per register written by the bus
us_collide  out  1  user write dropped because of a collision
us_regs  out  DEPTH*DATAW  flattened live register contents; register i occupies bits [i*DATAW +: DATAW]

Behaviour:
- Reset (asynchronous, rst_n=0):
  - all registers 0; sl_readdata 0; sl_response 00; us_wstrobe 0; us_collide 0.
  - sl_waitrequest 0; FSM returns to IDLE.
  - Any transaction in flight is abandoned.
- FSM states: IDLE, RWAIT, RDONE.
- IDLE, sl_read=1, RD_WAIT=0:
  - go to RDONE directly.
  - sl_waitrequest stays 0.
  - readdata and response are registered, so data appears on the cycle after the read is accepted.
- IDLE, sl_read=1, RD_WAIT>0:
  - sl_waitrequest is asserted combinationally from the first cycle.
  - Enter RWAIT and load counter = RD_WAIT-1.
  - Hold waitrequest while counter != 0; decrement each cycle.
  - At 0: latch readdata, deassert waitrequest for one cycle (RDONE), then IDLE.
  - A read therefore completes in exactly RD_WAIT+1 cycles.
- Master holds sl_addr and sl_read stable while sl_waitrequest=1. Changes during RWAIT are ignored; the address is sampled at entry.
- Write:
  - Accepted in IDLE, zero wait states.
  - Per byte lane: reg[a][8k+7:8k] <= sl_writedata[8k+7:8k] when sl_byteenable[k]=1.
  - us_wstrobe[a] pulses 1 cycle on the following edge, including when sl_byteenable is all zeros.
- RO register bus write: data is unchanged, sl_response=10 for that cycle, no strobe.
- Address >= DEPTH:
  - Read returns 0 with sl_response=10.
  - Write is ignored with sl_response=10.
- sl_read and sl_write both 1 in IDLE: write wins; the read is not serviced; sl_response=10.
- User-side write:
  - us_write=1 updates reg[us_addr] fully, regardless of RO_MASK.
  - Ignored if us_addr >= DEPTH.
- Same-cycle bus write and user write to the same address: bus data wins; us_collide pulses 1 cycle.
  - Different addresses: both complete.
- Bus write accepted in a cycle where a read is latching the same address: readdata returns the pre-write value.
- sl_response holds its value until the next accepted transaction.

Test Plan:
1. Reset, then read addr 3 with RD_WAIT=2 -> sl_waitrequest high 2 cycles; readdata=0x00000000; response 00.
2. Write 0xA5A5A5A5 to addr 1 with byteenable 4'b0101 over existing 0x11223344 -> reg1=0x11A533A5; us_wstrobe[1] pulses once.
3. Write 0xDEADBEEF to RO register 2 (RO_MASK bit2=1) -> reg2 unchanged; response 10. Then us_write to addr 2 with 0xCAFE0001 -> bus read returns 0xCAFE0001.
4. Same cycle: bus write 0x1 and us_write 0x2, both to addr 5 -> reg5=0x1; us_collide=1 for one cycle. Repeat with us_addr=6 -> reg5=0x1, reg6=0x2, no collide.
5. Read addr 0x20 with DEPTH=16 -> readdata 0, response 10. Write to 0x20 -> no register changes.
6. Assert rst_n=0 mid-RWAIT -> waitrequest drops immediately; all regs 0; the next read completes normally in RD_WAIT+1 cycles.
